// File: rtl/branch_pkg.sv
// Shared branch definitions: funct3 condition encodings and the BHT counter type.
package branch_pkg;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'b000,
      BR_BNE  = 3'b001,
      BR_BLT  = 3'b100,
      BR_BGE  = 3'b101,
      BR_BLTU = 3'b110,
      BR_BGEU = 3'b111
   } branch_cond_t;

   typedef logic [1:0] bht_ctr_t;

   // Weakly not-taken
   localparam bht_ctr_t BHT_CTR_RESET = 2'b01;

endpackage

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters; asynchronous read, one write per cycle.
module branch_bht
   import branch_pkg::*;
#(
   parameter int unsigned ENTRIES = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [$clog2(ENTRIES)-1:0] rd_idx,
   output logic                       rd_taken,
   input  logic                       wr_en,
   input  logic [$clog2(ENTRIES)-1:0] wr_idx,
   input  logic                       wr_taken
);

   bht_ctr_t ctr [ENTRIES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            ctr[i] <= BHT_CTR_RESET;
         end
      end else if (wr_en) begin
         if (wr_taken) begin
            if (ctr[wr_idx] != 2'b11) ctr[wr_idx] <= ctr[wr_idx] + 2'b01;
         end else begin
            if (ctr[wr_idx] != 2'b00) ctr[wr_idx] <= ctr[wr_idx] - 2'b01;
         end
      end
   end

   // Read sees the stored value, so a same-cycle write to the same index is not forwarded
   assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch compare/resolve stage with a one-entry result register and optional BHT.
// Optional predictor table is built in when BRANCH_RESOLVE_BHT_EN is defined.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned BHT_ENTRIES = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      branch_cond,
   input  logic [XLEN-1:0] rdata1,
   input  logic [XLEN-1:0] rdata2,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] target,
   input  logic            pred_taken,
   input  logic            flush,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            lookup_taken,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            taken,
   output logic            mispredict,
   output logic            illegal,
   output logic [XLEN-1:0] redirect_pc
);

   logic accept;
   logic cond_taken;
   logic cond_illegal;

   assign in_ready = (!out_valid || out_ready) && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      cond_taken   = 1'b0;
      cond_illegal = 1'b0;
      case (branch_cond)
         BR_BEQ:  cond_taken = (rdata1 == rdata2);
         BR_BNE:  cond_taken = (rdata1 != rdata2);
         BR_BLT:  cond_taken = ($signed(rdata1) <  $signed(rdata2));
         BR_BGE:  cond_taken = ($signed(rdata1) >= $signed(rdata2));
         BR_BLTU: cond_taken = (rdata1 <  rdata2);
         BR_BGEU: cond_taken = (rdata1 >= rdata2);
         default: cond_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         taken       <= 1'b0;
         mispredict  <= 1'b0;
         illegal     <= 1'b0;
         redirect_pc <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         taken       <= cond_taken;
         mispredict  <= cond_taken ^ pred_taken;
         illegal     <= cond_illegal;
         redirect_pc <= cond_taken ? target : pc + XLEN'(4);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef BRANCH_RESOLVE_BHT_EN
   localparam int unsigned IDXW = $clog2(BHT_ENTRIES);

   logic unused_lookup;
   assign unused_lookup = ^{lookup_pc[XLEN-1:IDXW+2], lookup_pc[1:0]};

   branch_bht #(
      .ENTRIES(BHT_ENTRIES)
   ) u_bht (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (lookup_pc[IDXW+1:2]),
      .rd_taken (lookup_taken),
      .wr_en    (accept && !cond_illegal),
      .wr_idx   (pc[IDXW+1:2]),
      .wr_taken (cond_taken)
   );
`else
   logic unused_lookup;
   assign unused_lookup = ^lookup_pc;
   assign lookup_taken  = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: compare vectors, handshake, flush, reset and BHT training.
module tb_branch_resolve_unit;
   import branch_pkg::*;

`ifdef BRANCH_RESOLVE_BHT_EN
   localparam logic BHT_ON = 1'b1;
`else
   localparam logic BHT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  branch_cond;
   logic [31:0] rdata1, rdata2, pc, target, lookup_pc, redirect_pc;
   logic        pred_taken, flush, lookup_taken, out_valid, out_ready;
   logic        taken, mispredict, illegal;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(64)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .branch_cond(branch_cond), .rdata1(rdata1), .rdata2(rdata2),
      .pc(pc), .target(target), .pred_taken(pred_taken), .flush(flush),
      .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
      .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
      .mispredict(mispredict), .illegal(illegal), .redirect_pc(redirect_pc)
   );

   typedef struct {
      logic [2:0]  cond;
      logic [31:0] a, b, bpc, tgt;
      logic        pred;
      logic        e_taken, e_mis, e_ill;
      logic [31:0] e_redir;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] t, input logic pr);
      branch_cond = c; rdata1 = a; rdata2 = b; pc = p; target = t; pred_taken = pr;
   endtask

   logic [31:0] held_redir;

   initial begin
      vecs[0] = '{3'b000, 32'd5, 32'd5, 32'h200, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300};
      vecs[1] = '{3'b001, 32'd5, 32'd5, 32'h200, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 32'h204};
      vecs[2] = '{3'b100, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h80, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80};
      vecs[3] = '{3'b110, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h180, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104};
      vecs[4] = '{3'b101, 32'd1, 32'hFFFFFFFF, 32'h10, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20};
      vecs[5] = '{3'b111, 32'd1, 32'hFFFFFFFF, 32'h10, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h14};
      vecs[6] = '{3'b101, 32'd7, 32'd7, 32'h30, 32'h44, 1'b1, 1'b1, 1'b0, 1'b0, 32'h44};
      vecs[7] = '{3'b010, 32'd1, 32'd2, 32'h500, 32'h600, 1'b0, 1'b0, 1'b0, 1'b1, 32'h504};
      vecs[8] = '{3'b011, 32'd3, 32'd3, 32'hFFFFFFFC, 32'h10, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
      vecs[9] = '{3'b110, 32'd0, 32'd1, 32'h8, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      lookup_pc = 32'h40;
      drive(3'b000, '0, '0, '0, '0, 1'b0);
      repeat (2) @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_taken", {31'd0, taken}, 32'd0);
      chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      chk("rst_redirect", redirect_pc, 32'd0);
      chk("rst_lookup", {31'd0, lookup_taken}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // BHT training: three taken BEQ at 0x40; lookup shows pre-update value in the accept cycle
      drive(3'b000, 32'd9, 32'd9, 32'h40, 32'h90, 1'b0);
      in_valid = 1'b1;
      #1 chk("bht_same_cycle_pre", {31'd0, lookup_taken}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("bht_after_%0d", i + 1), {31'd0, lookup_taken}, {31'd0, BHT_ON});
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("idle_clears_valid", {31'd0, out_valid}, 32'd0);

      // Illegal at fresh index 31 must not decrement; a following taken BEQ then reads 1
      lookup_pc = 32'h7C;
      drive(3'b010, 32'd1, 32'd1, 32'h7C, 32'h90, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      chk("ill_illegal", {31'd0, illegal}, 32'd1);
      chk("ill_taken", {31'd0, taken}, 32'd0);
      drive(3'b000, 32'd1, 32'd1, 32'h7C, 32'h90, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("ill_bht_unchanged", {31'd0, lookup_taken}, {31'd0, BHT_ON});

      // Vector table with back-to-back accept and consume
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].cond, vecs[i].a, vecs[i].b, vecs[i].bpc, vecs[i].tgt, vecs[i].pred);
         in_valid = 1'b1;
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("v%0d_taken", i), {31'd0, taken}, {31'd0, vecs[i].e_taken});
         chk($sformatf("v%0d_mis", i), {31'd0, mispredict}, {31'd0, vecs[i].e_mis});
         chk($sformatf("v%0d_ill", i), {31'd0, illegal}, {31'd0, vecs[i].e_ill});
         chk($sformatf("v%0d_redir", i), redirect_pc, vecs[i].e_redir);
      end
      in_valid = 1'b0;
      @(negedge clk);

      // Backpressure: hold result A while B waits, then accept B as A drains
      drive(3'b000, 32'd1, 32'd1, 32'h1000, 32'h2000, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      held_redir = redirect_pc;
      chk("bp_a_redir", held_redir, 32'h2000);
      out_ready = 1'b0;
      drive(3'b001, 32'd1, 32'd1, 32'h3000, 32'h4000, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("bp_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
         @(negedge clk);
         chk($sformatf("bp_hold_redir_%0d", i), redirect_pc, 32'h2000);
         chk($sformatf("bp_hold_mis_%0d", i), {31'd0, mispredict}, 32'd1);
         chk($sformatf("bp_hold_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk("bp_b_redir", redirect_pc, 32'h3004);
      chk("bp_b_mis", {31'd0, mispredict}, 32'd1);
      chk("bp_b_valid", {31'd0, out_valid}, 32'd1);

      // Flush beats a same-cycle consume and blocks input
      flush = 1'b1;
      drive(3'b000, 32'd2, 32'd2, 32'h5000, 32'h6000, 1'b0);
      #1 chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_clears_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_no_accept", redirect_pc, 32'h3004);

      // Asynchronous reset mid-operation discards the held result
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_redir", redirect_pc, 32'd0);
      lookup_pc = 32'h40;
      #1 chk("async_rst_bht", {31'd0, lookup_taken}, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
